demux_2s_reg: RTL and testbench

- Registered 1-to-4 demultiplexer: the distributing end of the 4:1 select path (mux_2s).
- Steers one W-bit input word to one of four output channels, chosen by a 2-bit select.
- Each channel has a one-entry output buffer with valid/ready handshake and a delivered-word counter.
- Sits between a single producer and four independent consumers.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_chan_buf.sv | 40 ++++
 rtl/demux_2s_reg.sv | 65 ++++++
 tb/tb_demux_2s_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1-to-4 demultiplexer.
// Channel count and select width live here so the top and the testbench agree.
package demux_pkg;

  localparam int NCH = 4;
  localparam int SW  = 2;

  // A select value becomes a one-hot mask that is later qualified by the accept condition.
  function automatic logic [NCH-1:0] sel_onehot(input logic [SW-1:0] sel);
    logic [NCH-1:0] mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One output channel: a single-entry buffer with valid/ready handshake
// and a wrapping count of words delivered to the consumer.
module demux_chan_buf #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ordy,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  logic pop;

  assign pop = valid & ordy;

  // The top only pushes when the slot is empty or draining, so a push never overwrites an undelivered word.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        dout  <= din;
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (pop) begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/demux_2s_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word to the channel named by s,
// each channel buffering one word, plus a registered readback of a per-channel delivered count.
module demux_2s_reg
  import demux_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  d,
  input  logic [1:0]    s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  o0,
  output logic [W-1:0]  o1,
  output logic [W-1:0]  o2,
  output logic [W-1:0]  o3,
  output logic [3:0]    ov,
  input  logic [3:0]    ordy,
  input  logic [1:0]    cnt_sel,
  output logic [CW-1:0] cnt
);

  logic [NCH-1:0] push_en;
  logic [W-1:0]   dout_arr  [NCH];
  logic [CW-1:0]  count_arr [NCH];
  logic           accept;

  // Ready depends only on the selected slot, so a full channel stalls the producer without blocking others.
  assign in_ready = !ov[s] | ordy[s];
  assign accept   = in_valid & in_ready;
  assign push_en  = sel_onehot(s) & {NCH{accept}};

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    demux_chan_buf #(
      .W  (W),
      .CW (CW)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[k]),
      .din   (d),
      .ordy  (ordy[k]),
      .dout  (dout_arr[k]),
      .valid (ov[k]),
      .count (count_arr[k])
    );
  end

  assign o0 = dout_arr[0];
  assign o1 = dout_arr[1];
  assign o2 = dout_arr[2];
  assign o3 = dout_arr[3];

  // The readback samples the counter as it stood before this edge's increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= count_arr[cnt_sel];
    end
  end

endmodule

// File: tb/tb_demux_2s_reg.sv
// Self-checking bench for demux_2s_reg: per-channel scoreboard queues are filled on accepted
// pushes and drained/compared when the DUT hands a word to a consumer.
module tb_demux_2s_reg;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  d;
  logic [1:0]    s;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  o0, o1, o2, o3;
  logic [3:0]    ov;
  logic [3:0]    ordy;
  logic [1:0]    cnt_sel;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  sb_q [4][$];
  logic [W-1:0]  last_word [4];
  logic [CW-1:0] model_cnt [4];
  logic [CW-1:0] exp_cnt;
  bit            model_ok = 1'b0;

  demux_2s_reg #(.W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .ov       (ov),
    .ordy     (ordy),
    .cnt_sel  (cnt_sel),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] dut_o(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      2:       return o2;
      default: return o3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] sel,
                               input logic [W-1:0] data, input logic [3:0] rdy,
                               input logic [1:0] csel);
    rst      = r;
    in_valid = iv;
    s        = sel;
    d        = data;
    ordy     = rdy;
    cnt_sel  = csel;
    #1;
  endtask

  // Checks the DUT against the scoreboard at the negedge, then advances the model across the posedge.
  task automatic stepClock();
    logic [3:0] exp_ov;
    logic       exp_rdy;
    logic [CW-1:0] next_cnt;
    @(negedge clk);
    for (int k = 0; k < 4; k++) exp_ov[k] = (sb_q[k].size() > 0);
    exp_rdy = !exp_ov[s] | ordy[s];
    if (model_ok) begin
      checkOutput("ov", 32'(ov), 32'(exp_ov));
      checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
      checkOutput("cnt", 32'(cnt), 32'(exp_cnt));
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("o%0d", k), 32'(dut_o(k)),
                    32'(exp_ov[k] ? sb_q[k][0] : last_word[k]));
      end
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        sb_q[k].delete();
        last_word[k] = '0;
        model_cnt[k] = '0;
      end
      exp_cnt  = '0;
      model_ok = 1'b1;
    end else begin
      next_cnt = model_cnt[cnt_sel];
      for (int k = 0; k < 4; k++) begin
        if (exp_ov[k] && ordy[k]) begin
          last_word[k] = sb_q[k].pop_front();
          model_cnt[k] = model_cnt[k] + CW'(1);
        end
      end
      if (in_valid && exp_rdy) sb_q[s].push_back(d);
      exp_cnt = next_cnt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd0);
    stepClock();
    stepClock();

    // Reset state and basic route to channel 2
    checkOutput("rst_ov", 32'(ov), 32'h0);
    checkOutput("rst_cnt", 32'(cnt), 32'h0);
    applyStimulus(1'b0, 1'b1, 2'd2, 4'hA, 4'b0000, 2'd0);
    stepClock();
    checkOutput("route_ov", 32'(ov), 32'b0100);
    checkOutput("route_o2", 32'(o2), 32'hA);
    checkOutput("route_o0", 32'(o0), 32'h0);
    checkOutput("route_o1", 32'(o1), 32'h0);
    checkOutput("route_o3", 32'(o3), 32'h0);

    // Backpressure on a full channel, then release with a same-cycle push and pop
    applyStimulus(1'b0, 1'b1, 2'd2, 4'h5, 4'b0000, 2'd2);
    checkOutput("bp_rdy_low", 32'(in_ready), 32'h0);
    stepClock();
    checkOutput("bp_o2_hold", 32'(o2), 32'hA);
    applyStimulus(1'b0, 1'b1, 2'd2, 4'h5, 4'b0100, 2'd2);
    checkOutput("bp_rdy_high", 32'(in_ready), 32'h1);
    stepClock();
    checkOutput("bp_o2_new", 32'(o2), 32'h5);
    checkOutput("bp_ov2", 32'(ov[2]), 32'h1);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd2);
    stepClock();
    checkOutput("bp_cnt2", 32'(cnt), 32'h1);

    // Streaming round-robin with all consumers ready
    applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd0);
    stepClock();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 2'(i % 4), 4'((i % 4) + 1), 4'b1111, 2'd0);
      checkOutput("stream_rdy", 32'(in_ready), 32'h1);
      stepClock();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b1111, 2'd0);
    stepClock();
    checkOutput("stream_drained", 32'(ov), 32'h0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000, 2'(k));
      stepClock();
      checkOutput($sformatf("stream_cnt%0d", k), 32'(cnt), 32'd4);
    end

    // Counter wrap on channel 0
    applyStimulus(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd0);
    stepClock();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd0, 4'(i), 4'b0001, 2'd0);
      stepClock();
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0001, 2'd0);
    stepClock();
    checkOutput("wrap_255", 32'(cnt), 32'd255);
    stepClock();
    checkOutput("wrap_0", 32'(cnt), 32'd0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000, 2'(k));
      stepClock();
      checkOutput($sformatf("wrap_other%0d", k), 32'(cnt), 32'd0);
    end

    // Reset in the middle of traffic with channels 1 and 3 holding words
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 2'd1, 4'(i + 3), 4'b0010, 2'd1);
      stepClock();
    end
    applyStimulus(1'b0, 1'b1, 2'd3, 4'hC, 4'b0000, 2'd1);
    stepClock();
    checkOutput("mid_setup_ov", 32'(ov), 32'b1010);
    checkOutput("mid_setup_cnt1", 32'(cnt), 32'd7);
    applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 4'b0000, 2'd1);
    stepClock();
    checkOutput("mid_ov", 32'(ov), 32'h0);
    checkOutput("mid_o1", 32'(o1), 32'h0);
    checkOutput("mid_o3", 32'(o3), 32'h0);
    checkOutput("mid_cnt", 32'(cnt), 32'h0);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd1);
    stepClock();
    checkOutput("mid_cnt1", 32'(cnt), 32'h0);

    // Pop on channel 0 alongside a push to channel 3
    applyStimulus(1'b0, 1'b1, 2'd0, 4'h6, 4'b0000, 2'd0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 2'd3, 4'h9, 4'b0001, 2'd0);
    stepClock();
    checkOutput("simul_ov", 32'(ov), 32'b1000);
    checkOutput("simul_o3", 32'(o3), 32'h9);
    applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, 4'b0000, 2'd0);
    stepClock();
    checkOutput("simul_cnt0", 32'(cnt), 32'd1);

    // Random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)));
      stepClock();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
